// File: rtl/id_ex_pkg.sv
// Shared types and width helpers for the ID/EX elastic pipeline stage.
package id_ex_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned CTRL_W = 4;

  // Packed entry layout: {ALUctrl, Data1, Data2, Rd, RegWrite}
  function automatic int unsigned payload_w(input int unsigned ctrl_w,
                                            input int unsigned data_w,
                                            input int unsigned rd_w);
    return ctrl_w + 2 * data_w + rd_w + 1;
  endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Payload register with load enable and asynchronous active-high clear.
module pipe_payload_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) q <= '0;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/id_ex_elastic_stage.sv
// ID/EX stage with valid/ready handshake, two-entry skid buffer, flush and
// a saturating counter of upstream stall cycles.
module id_ex_elastic_stage #(
  parameter int unsigned DATA_W = id_ex_pkg::DATA_W,
  parameter int unsigned RD_W   = id_ex_pkg::RD_W,
  parameter int unsigned CTRL_W = id_ex_pkg::CTRL_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ALUctrl,
  input  logic [DATA_W-1:0] Data1,
  input  logic [DATA_W-1:0] Data2,
  input  logic [RD_W-1:0]   Rd,
  input  logic              RegWrite,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ALUctrl_ID_EX,
  output logic [DATA_W-1:0] Data1_ID_EX,
  output logic [DATA_W-1:0] Data2_ID_EX,
  output logic [RD_W-1:0]   Rd_ID_EX,
  output logic              RegWrite_ID_EX,
  output logic [CNT_W-1:0]  stall_cnt
);

  import id_ex_pkg::*;

  localparam int unsigned PW       = payload_w(CTRL_W, DATA_W, RD_W);
  localparam int unsigned RD_LSB   = 1;
  localparam int unsigned D2_LSB   = RD_LSB + RD_W;
  localparam int unsigned D1_LSB   = D2_LSB + DATA_W;
  localparam int unsigned CTRL_LSB = D1_LSB + DATA_W;

  state_t        state_q, state_d;
  logic          ld_main, ld_skid, main_from_skid;
  logic          in_fire, out_fire;
  logic [PW-1:0] in_payload, main_d, main_q, skid_q;

  assign in_ready   = (state_q != FULL);
  assign out_valid  = (state_q != EMPTY);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign in_payload = {ALUctrl, Data1, Data2, Rd, RegWrite};
  assign main_d     = main_from_skid ? skid_q : in_payload;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= EMPTY;
    else state_q <= state_d;
  end

  // Next state and entry load enables; flush overrides every transfer
  always_comb begin
    state_d        = state_q;
    ld_main        = 1'b0;
    ld_skid        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          ld_main = 1'b1;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          ld_main = 1'b1;
        end else if (in_fire) begin
          ld_skid = 1'b1;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          ld_main        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      ld_main = 1'b0;
      ld_skid = 1'b0;
    end
  end

  pipe_payload_reg #(.W(PW)) u_main (
    .clk (Clk),
    .clr (Reset),
    .ld  (ld_main),
    .d   (main_d),
    .q   (main_q)
  );

  pipe_payload_reg #(.W(PW)) u_skid (
    .clk (Clk),
    .clr (Reset),
    .ld  (ld_skid),
    .d   (in_payload),
    .q   (skid_q)
  );

  assign ALUctrl_ID_EX  = main_q[CTRL_LSB +: CTRL_W];
  assign Data1_ID_EX    = main_q[D1_LSB +: DATA_W];
  assign Data2_ID_EX    = main_q[D2_LSB +: DATA_W];
  assign Rd_ID_EX       = main_q[RD_LSB +: RD_W];
  assign RegWrite_ID_EX = main_q[0] && out_valid;

  // Saturating stall counter; survives flush
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) stall_cnt <= '0;
    else if (in_valid && !in_ready && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule
